rot_undo_stack: RTL and testbench

- Records the cube-rotation opcodes issued to the ALU in a LIFO history and replays them in reverse on request, emitting the inverse rotation of each.
- Feeding its output back into the ALU returns every orientation code to its state before the recorded sequence.
- Sits beside the ALU on the opcode path: the sequencer pushes each executed rotation here, and the undo stream goes back to the ALU opcode mux.

---
 rtl/rot_undo_stack_pkg.sv | 39 +++
 rtl/rot_undo_stack_rot_inv.sv | 23 ++
 rtl/rot_undo_stack.sv | 133 +++++++++++++
 tb/tb_rot_undo_stack.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rot_undo_stack_pkg.sv
// Shared opcode encodings, unwind FSM state encodings and the rotation-membership test
// used by the ALU sequencer, the undo stack and the inverse mapper.
package rot_undo_stack_pkg;

    localparam logic [4:0] OP_INC    = 5'd0;
    localparam logic [4:0] OP_DEC    = 5'd1;
    localparam logic [4:0] OP_CHECK  = 5'd2;
    localparam logic [4:0] OP_LOAD   = 5'd3;
    localparam logic [4:0] OP_STORE  = 5'd4;
    localparam logic [4:0] OP_LI     = 5'd5;
    localparam logic [4:0] OP_MOV    = 5'd6;
    localparam logic [4:0] OP_RL_90  = 5'd8;
    localparam logic [4:0] OP_RL_180 = 5'd9;
    localparam logic [4:0] OP_RL_270 = 5'd10;
    localparam logic [4:0] OP_UD_90  = 5'd11;
    localparam logic [4:0] OP_UD_180 = 5'd12;
    localparam logic [4:0] OP_UD_270 = 5'd13;
    localparam logic [4:0] OP_FB_90  = 5'd14;
    localparam logic [4:0] OP_FB_180 = 5'd15;
    localparam logic [4:0] OP_FB_270 = 5'd16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_UNWIND = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    function automatic logic is_rot(input logic [4:0] op);
        logic r;
        case (op)
            OP_RL_90, OP_RL_180, OP_RL_270,
            OP_UD_90, OP_UD_180, OP_UD_270,
            OP_FB_90, OP_FB_180, OP_FB_270: r = 1'b1;
            default:                        r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/rot_undo_stack_rot_inv.sv
// Combinational inverse of a cube rotation: 90 and 270 swap within an axis, 180 is
// self-inverse, anything that is not a rotation passes through untouched.
module rot_inv
    import rot_undo_stack_pkg::*;
(
    input  logic [4:0] i_op,
    output logic [4:0] o_op
);

    always_comb begin
        o_op = i_op;
        case (i_op)
            OP_RL_90:  o_op = OP_RL_270;
            OP_RL_270: o_op = OP_RL_90;
            OP_UD_90:  o_op = OP_UD_270;
            OP_UD_270: o_op = OP_UD_90;
            OP_FB_90:  o_op = OP_FB_270;
            OP_FB_270: o_op = OP_FB_90;
            default:   o_op = i_op;
        endcase
    end

endmodule

// File: rtl/rot_undo_stack.sv
// LIFO history of executed rotations; on undo_start it streams the inverse of every
// entry, newest first, over a valid/ready port and then pulses undo_done.
module rot_undo_stack
    import rot_undo_stack_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CW    = 5
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clear,
    input  logic          i_push_valid,
    input  logic [4:0]    i_push_op,
    output logic          o_push_ready,
    input  logic          i_undo_start,
    output logic          o_undo_valid,
    output logic [4:0]    o_undo_op,
    input  logic          i_undo_ready,
    output logic          o_undo_done,
    output logic [CW-1:0] o_count,
    output logic          o_overflow,
    output logic          o_bad_op,
    output state_t        o_state
);

    localparam int AW = CW - 1;

    // Undo handshake: a transfer happens on an edge where o_undo_valid and
    // i_undo_ready are both high; o_undo_op is held while valid is high and ready is low.

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_count;
    logic            r_overflow;
    logic            r_bad_op;
    logic [4:0]      r_mem [DEPTH];

    logic            w_idle;
    logic            w_is_rot;
    logic            w_full;
    logic            w_push_ok;
    logic            w_pop;
    logic [AW-1:0]   w_rd_idx;
    logic [4:0]      w_top_op;

    assign w_idle    = (r_state == ST_IDLE);
    assign w_is_rot  = is_rot(i_push_op);
    assign w_full    = (r_count == CW'(DEPTH));
    assign w_push_ok = w_idle && i_push_valid && w_is_rot && !w_full;
    assign w_pop     = (r_state == ST_UNWIND) && i_undo_ready && (r_count != '0);
    assign w_rd_idx  = r_count[AW-1:0] - AW'(1);
    assign w_top_op  = r_mem[w_rd_idx];

    rot_inv u_rot_inv (
        .i_op (w_top_op),
        .o_op (o_undo_op)
    );

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a push in the same cycle as undo_start counts toward "non-empty"
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_undo_start) begin
                    w_state_nxt = (w_push_ok || (r_count != '0)) ? ST_UNWIND : ST_DONE;
                end
            end
            ST_UNWIND: begin
                if (w_pop && (r_count == CW'(1))) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
        if (i_clear) begin
            w_state_nxt = ST_IDLE;
        end
    end

    // Output decode
    always_comb begin
        o_push_ready = w_idle && !w_full;
        o_undo_valid = (r_state == ST_UNWIND);
        o_undo_done  = (r_state == ST_DONE);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_bad_op   <= 1'b0;
        end else if (i_clear) begin
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_bad_op   <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop) begin
                r_count <= r_count - CW'(1);
            end
            if (w_idle && i_push_valid && !w_is_rot) begin
                r_bad_op <= 1'b1;
            end
            if (w_idle && i_push_valid && w_is_rot && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // History storage has no reset; only entries below r_count are ever read
    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            r_mem[r_count[AW-1:0]] <= i_push_op;
        end
    end

    assign o_count    = r_count;
    assign o_overflow = r_overflow;
    assign o_bad_op   = r_bad_op;
    assign o_state    = r_state;

endmodule

// File: tb/tb_rot_undo_stack.sv
// Directed bench for rot_undo_stack: one task per scenario, inline checks, one summary.
module tb_rot_undo_stack;
    import rot_undo_stack_pkg::*;

    localparam int DEPTH = 16;
    localparam int CW    = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clear = 1'b0;
    logic          push_valid = 1'b0;
    logic [4:0]    push_op = '0;
    logic          push_ready;
    logic          undo_start = 1'b0;
    logic          undo_valid;
    logic [4:0]    undo_op;
    logic          undo_ready = 1'b0;
    logic          undo_done;
    logic [CW-1:0] count;
    logic          overflow;
    logic          bad_op;
    state_t        state;

    int n_tests = 0;
    int n_fail  = 0;

    logic [4:0] rot_tab [9] = '{OP_RL_90, OP_RL_180, OP_RL_270, OP_UD_90, OP_UD_180,
                                OP_UD_270, OP_FB_90, OP_FB_180, OP_FB_270};
    logic [4:0] inv_tab [9] = '{OP_RL_270, OP_RL_180, OP_RL_90, OP_UD_270, OP_UD_180,
                                OP_UD_90, OP_FB_270, OP_FB_180, OP_FB_90};
    logic [4:0] exp_q [$];

    always #5 clk = ~clk;

    rot_undo_stack #(.DEPTH(DEPTH), .CW(CW)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_clear      (clear),
        .i_push_valid (push_valid),
        .i_push_op    (push_op),
        .o_push_ready (push_ready),
        .i_undo_start (undo_start),
        .o_undo_valid (undo_valid),
        .o_undo_op    (undo_op),
        .i_undo_ready (undo_ready),
        .o_undo_done  (undo_done),
        .o_count      (count),
        .o_overflow   (overflow),
        .o_bad_op     (bad_op),
        .o_state      (state)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [4:0] op);
        push_valid = 1'b1;
        push_op    = op;
        step();
        push_valid = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        n_tests++;
        if ({count, undo_valid, undo_done, overflow, bad_op, push_ready} !== {5'd0, 5'b00001}) begin
            n_fail++;
            $display("FAIL reset_outputs: count=%0d valid=%b done=%b ovf=%b bad=%b pready=%b", count, undo_valid, undo_done, overflow, bad_op, push_ready);
        end
        n_tests++;
        if (state !== ST_IDLE) begin
            n_fail++;
            $display("FAIL reset_state: got %0d want %0d", state, ST_IDLE);
        end
        @(negedge clk);
        rst = 1'b0;
        step();
    endtask

    task automatic test_inverse();
        logic [4:0] want [3] = '{OP_FB_90, OP_UD_180, OP_RL_270};
        push(OP_RL_90);
        push(OP_UD_180);
        push(OP_FB_270);
        n_tests++;
        if (count !== 5'd3) begin
            n_fail++;
            $display("FAIL inv_count_after_push: got %0d want 3", count);
        end
        undo_start = 1'b1;
        undo_ready = 1'b1;
        step();
        undo_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if ({undo_valid, undo_op} !== {1'b1, want[i]}) begin
                n_fail++;
                $display("FAIL inv_op%0d: valid=%b op=%0d want valid=1 op=%0d", i, undo_valid, undo_op, want[i]);
            end
            step();
        end
        n_tests++;
        if ({undo_done, undo_valid, count} !== {1'b1, 1'b0, 5'd0}) begin
            n_fail++;
            $display("FAIL inv_done: done=%b valid=%b count=%0d want 1 0 0", undo_done, undo_valid, count);
        end
        step();
        n_tests++;
        if ({undo_done, state} !== {1'b0, ST_IDLE}) begin
            n_fail++;
            $display("FAIL inv_done_one_cycle: done=%b state=%0d", undo_done, state);
        end
        undo_ready = 1'b0;
    endtask

    task automatic test_overflow();
        int  emitted;
        bit  seen_done;
        do_clear();
        exp_q.delete();
        for (int i = 0; i < 17; i++) begin
            if (i < DEPTH) exp_q.push_back(inv_tab[i % 9]);
            push(rot_tab[i % 9]);
        end
        n_tests++;
        if ({count, overflow, push_ready} !== {5'd16, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL ovf_flags: count=%0d ovf=%b pready=%b want 16 1 0", count, overflow, push_ready);
        end
        undo_start = 1'b1;
        step();
        undo_start = 1'b0;
        undo_ready = 1'b1;
        emitted   = 0;
        seen_done = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (undo_done) begin
                seen_done = 1'b1;
                break;
            end
            if (undo_valid) begin
                emitted++;
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL ovf_extra_op: got op %0d with nothing expected", undo_op);
                end else if (undo_op !== exp_q[$]) begin
                    n_fail++;
                    $display("FAIL ovf_op: got %0d want %0d", undo_op, exp_q[$]);
                    void'(exp_q.pop_back());
                end else begin
                    void'(exp_q.pop_back());
                end
            end
            step();
        end
        undo_ready = 1'b0;
        n_tests++;
        if ({seen_done, emitted} !== {1'b1, 32'd16}) begin
            n_fail++;
            $display("FAIL ovf_unwind_len: done_seen=%b emitted=%0d want 1 16", seen_done, emitted);
        end
        n_tests++;
        if (overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_sticky: got %b want 1", overflow);
        end
    endtask

    task automatic test_bad_op();
        do_clear();
        push(OP_INC);
        push(OP_LOAD);
        push(OP_RL_180);
        n_tests++;
        if ({bad_op, count, overflow} !== {1'b1, 5'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL bad_flags: bad=%b count=%0d ovf=%b want 1 1 0", bad_op, count, overflow);
        end
        undo_start = 1'b1;
        undo_ready = 1'b1;
        step();
        undo_start = 1'b0;
        n_tests++;
        if ({undo_valid, undo_op} !== {1'b1, OP_RL_180}) begin
            n_fail++;
            $display("FAIL bad_unwind_op: valid=%b op=%0d want 1 %0d", undo_valid, undo_op, OP_RL_180);
        end
        step();
        n_tests++;
        if ({undo_done, undo_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL bad_unwind_done: done=%b valid=%b want 1 0", undo_done, undo_valid);
        end
        undo_ready = 1'b0;
        step();
    endtask

    task automatic test_backpressure();
        do_clear();
        push(OP_UD_90);
        undo_start = 1'b1;
        undo_ready = 1'b0;
        step();
        undo_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if ({undo_valid, undo_op, count} !== {1'b1, OP_UD_270, 5'd1}) begin
                n_fail++;
                $display("FAIL bp_hold%0d: valid=%b op=%0d count=%0d want 1 %0d 1", i, undo_valid, undo_op, count, OP_UD_270);
            end
            step();
        end
        undo_ready = 1'b1;
        step();
        undo_ready = 1'b0;
        n_tests++;
        if ({undo_done, undo_valid, count} !== {1'b1, 1'b0, 5'd0}) begin
            n_fail++;
            $display("FAIL bp_done: done=%b valid=%b count=%0d want 1 0 0", undo_done, undo_valid, count);
        end
        step();
    endtask

    task automatic test_empty_undo();
        do_clear();
        undo_start = 1'b1;
        n_tests++;
        if (undo_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_valid_pulse: got %b want 0", undo_valid);
        end
        step();
        undo_start = 1'b0;
        n_tests++;
        if ({undo_done, undo_valid, state} !== {1'b1, 1'b0, ST_DONE}) begin
            n_fail++;
            $display("FAIL empty_done: done=%b valid=%b state=%0d want 1 0 %0d", undo_done, undo_valid, state, ST_DONE);
        end
        step();
        n_tests++;
        if ({undo_done, undo_valid, state} !== {1'b0, 1'b0, ST_IDLE}) begin
            n_fail++;
            $display("FAIL empty_after: done=%b valid=%b state=%0d want 0 0 0", undo_done, undo_valid, state);
        end
    endtask

    task automatic test_collision();
        do_clear();
        push_valid = 1'b1;
        push_op    = OP_FB_90;
        undo_start = 1'b1;
        step();
        push_valid = 1'b0;
        undo_start = 1'b0;
        n_tests++;
        if ({undo_valid, undo_op, count} !== {1'b1, OP_FB_270, 5'd1}) begin
            n_fail++;
            $display("FAIL coll_first_op: valid=%b op=%0d count=%0d want 1 %0d 1", undo_valid, undo_op, count, OP_FB_270);
        end
        // pushes during UNWIND are ignored and raise no flags
        push_valid = 1'b1;
        push_op    = OP_INC;
        step();
        push_valid = 1'b0;
        n_tests++;
        if ({count, bad_op, push_ready} !== {5'd1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL coll_push_ignored: count=%0d bad=%b pready=%b want 1 0 0", count, bad_op, push_ready);
        end
        undo_ready = 1'b1;
        step();
        undo_ready = 1'b0;
        step();
    endtask

    task automatic fill_and_start_unwind();
        do_clear();
        push(OP_MOV);
        for (int i = 0; i < 5; i++) push(rot_tab[i]);
        undo_start = 1'b1;
        undo_ready = 1'b1;
        step();
        undo_start = 1'b0;
        step();
        undo_ready = 1'b0;
    endtask

    task automatic test_abort_clear();
        fill_and_start_unwind();
        n_tests++;
        if ({undo_valid, count, bad_op} !== {1'b1, 5'd4, 1'b1}) begin
            n_fail++;
            $display("FAIL abort_pre: valid=%b count=%0d bad=%b want 1 4 1", undo_valid, count, bad_op);
        end
        clear      = 1'b1;
        undo_ready = 1'b1;
        step();
        clear      = 1'b0;
        undo_ready = 1'b0;
        n_tests++;
        if ({state, count, undo_done, undo_valid, bad_op, overflow, push_ready} !== {ST_IDLE, 5'd0, 5'b00001}) begin
            n_fail++;
            $display("FAIL abort_clear: state=%0d count=%0d done=%b valid=%b bad=%b ovf=%b pready=%b", state, count, undo_done, undo_valid, bad_op, overflow, push_ready);
        end
        step();
        n_tests++;
        if (undo_done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_clear_nodone: got %b want 0", undo_done);
        end
    endtask

    task automatic test_abort_rst();
        fill_and_start_unwind();
        #3;
        rst = 1'b1;
        #1;
        n_tests++;
        if ({state, count, undo_done, undo_valid, bad_op, push_ready} !== {ST_IDLE, 5'd0, 4'b0001}) begin
            n_fail++;
            $display("FAIL abort_rst: state=%0d count=%0d done=%b valid=%b bad=%b pready=%b", state, count, undo_done, undo_valid, bad_op, push_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        step();
        n_tests++;
        if ({undo_done, undo_valid, count} !== {1'b0, 1'b0, 5'd0}) begin
            n_fail++;
            $display("FAIL abort_rst_after: done=%b valid=%b count=%0d want 0 0 0", undo_done, undo_valid, count);
        end
    endtask

    initial begin
        test_reset();
        test_inverse();
        test_overflow();
        test_bad_op();
        test_backpressure();
        test_empty_undo();
        test_collision();
        test_abort_clear();
        test_abort_rst();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule
